// File: rtl/sfifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port burst arbiter.
// Holds the FSM state enum, a clog2 helper and the default burst cap.
package sfifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int MAX_BURST_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sfifo_wr_arb_if.sv
// FIFO write-side bundle between the arbiter (master) and the FIFO (slave).
// Carries write enable/data out and full/count back.
interface sfifo_wr_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output w_en,
    output data_in,
    input  full,
    input  count
  );

  modport slave (
    input  w_en,
    input  data_in,
    output full,
    output count
  );

endinterface

// File: rtl/sfifo_wr_arb_rr_pick.sv
// Round-robin picker: rotate requests by ptr, take the lowest set bit,
// then map the offset back to an absolute index modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    // ptr and off are both below N, so one subtraction wraps
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/sfifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Define SFIFO_WR_ARB_SPACE_CHECK_EN to grant only when MAX_BURST slots are free.
module sfifo_wr_arb
  import sfifo_wr_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  localparam int IW = clog2(N_REQ),
  localparam int BW = clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  sfifo_wr_arb_if.master              fifo,
  output logic [IW-1:0]               grant_id,
  output logic                        busy
);

  arb_state_t      state;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic            found;
  logic [IW-1:0]   pick;
  logic            room;
  logic            accept;
  logic            done;
  logic [IW-1:0]   nxt_ptr;
  logic [DATA_WIDTH-1:0] g_data;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick)
  );

`ifdef SFIFO_WR_ARB_SPACE_CHECK_EN
  logic [ADDR_WIDTH:0] space;
  assign space = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH) - fifo.count;
  assign room  = space >= (ADDR_WIDTH + 1)'(MAX_BURST);
`else
  logic unused_count;
  assign unused_count = ^fifo.count;
  assign room         = 1'b1;
`endif

  assign busy     = (state == BURST);
  assign grant_id = grant_q;
  assign g_data   = req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign accept   = busy & req[grant_q] & ~fifo.full;

  // last, cap and abandon all collapse into one end-of-burst
  assign done = ~req[grant_q]
              | (accept & req_last[grant_q])
              | (accept & (beat_cnt == BW'(MAX_BURST - 1)));

  assign nxt_ptr = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  assign ack          = N_REQ'(accept) << grant_q;
  assign fifo.w_en    = accept;
  assign fifo.data_in = busy ? g_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found && room) begin
            grant_q  <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          if (done) begin
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Bench for sfifo_wr_arb: directed scenarios plus random traffic
// against a queue-based producer/FIFO reference model.
module tb_sfifo_wr_arb;
  import sfifo_wr_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int MB    = 4;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [1:0]      grant_id;
  logic            busy;

  sfifo_wr_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

  sfifo_wr_arb #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .ack      (ack),
    .fifo     (fifo_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // producer beat queues: {last, data}
  logic [8:0] bq [N][64];
  int  rd [N];
  int  wr [N];
  bit  en [N];
  int  seq [N];

  // reference state
  int owner;
  int ptr;
  int beats;
  int fcnt;
  int drain_pct;

  // observation logs
  int         stepno;
  bit         prev_busy;
  logic [7:0] wlog [64];
  int         wstep [64];
  int         nlog;
  int         glog [16];
  int         gstep [16];
  int         ng;

  task automatic push(input int i, input logic [7:0] d, input bit l);
    bq[i][wr[i] % 64] = {l, d};
    wr[i]++;
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      h = bq[i][rd[i] % 64];
      req[i] = en[i] && (wr[i] != rd[i]);
      req_last[i] = req[i] & h[8];
      req_data[i*DW +: DW] = h[7:0];
    end
    fifo_if.full  = (fcnt >= DEPTH);
    fifo_if.count = (AW + 1)'(fcnt);
  endtask

  task automatic check_cycle();
    logic [N-1:0] ea;
    bit           ew;
    logic [7:0]   ed;
    logic [8:0]   h;
    ea = '0;
    ew = 1'b0;
    ed = '0;
    stepno++;
    if (owner >= 0) begin
      h  = bq[owner][rd[owner] % 64];
      ed = h[7:0];
      if (req[owner] && fcnt < DEPTH) begin
        ea[owner] = 1'b1;
        ew = 1'b1;
      end
      chk("grant_id", 32'(grant_id), 32'(owner));
    end
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("ack", 32'(ack), 32'(ea));
    chk("w_en", 32'(fifo_if.w_en), 32'(ew));
    chk("data_in", 32'(fifo_if.data_in), 32'(ed));
    if (fifo_if.w_en && nlog < 64) begin
      wlog[nlog]  = fifo_if.data_in;
      wstep[nlog] = stepno;
      nlog++;
    end
    if (busy && !prev_busy && ng < 16) begin
      glog[ng]  = int'(grant_id);
      gstep[ng] = stepno;
      ng++;
    end
    prev_busy = busy;
  endtask

  task automatic model_update();
    bit         room;
    bit         acc;
    bit         lst;
    logic [8:0] h;
    acc = 1'b0;
    if (owner < 0) begin
      room = 1'b1;
`ifdef SFIFO_WR_ARB_SPACE_CHECK_EN
      room = (DEPTH - fcnt) >= MB;
`endif
      if (room) begin
        for (int k = 0; k < N; k++) begin
          if (req[(ptr + k) % N]) begin
            owner = (ptr + k) % N;
            beats = 0;
            break;
          end
        end
      end
    end else begin
      h   = bq[owner][rd[owner] % 64];
      lst = h[8];
      acc = req[owner] && fcnt < DEPTH;
      if (acc) begin
        rd[owner]++;
        beats++;
      end
      if (!req[owner] || (acc && (lst || beats == MB))) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end
    if (acc) fcnt++;
    if (fcnt > 0 && $urandom_range(99) < drain_pct) fcnt--;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_w_en", 32'(fifo_if.w_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(fifo_if.data_in), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    owner = -1;
    ptr   = 0;
    beats = 0;
    fcnt  = 0;
    drain_pct = 0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
      en[i] = 1'b0;
    end
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    stepno    = 0;
    prev_busy = 1'b0;
    nlog      = 0;
    ng        = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    fifo_if.full  = 1'b0;
    fifo_if.count = '0;
    do_reset();

    // single burst from producer 2, then pointer lands on 3
    push(2, 8'hA0, 1'b0);
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b1);
    en[2] = 1'b1;
    steps(5);
    chk("sb_grant", 32'(glog[0]), 32'd2);
    chk("sb_gstep", 32'(gstep[0]), 32'd2);
    chk("sb_nbeats", 32'(nlog), 32'd3);
    chk("sb_d0", 32'(wlog[0]), 32'hA0);
    chk("sb_d1", 32'(wlog[1]), 32'hA1);
    chk("sb_d2", 32'(wlog[2]), 32'hA2);
    chk("sb_s2", 32'(wstep[2]), 32'd4);
    push(0, 8'h05, 1'b1);
    push(3, 8'h35, 1'b1);
    en[0] = 1'b1;
    en[3] = 1'b1;
    steps(6);
    chk("sb_ptr3", 32'(glog[1]), 32'd3);
    chk("sb_then0", 32'(glog[2]), 32'd0);

    // round robin, bursts of two
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 8'(i * 16 + 0), 1'b0);
      push(i, 8'(i * 16 + 1), 1'b1);
      push(i, 8'(i * 16 + 2), 1'b0);
      push(i, 8'(i * 16 + 3), 1'b1);
      en[i] = 1'b1;
    end
    steps(12);
    chk("rr_8in12", 32'(nlog), 32'd8);
    steps(4);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(glog[k]), 32'(k % N));

    // cap with no last
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k), 1'b0);
    en[1] = 1'b1;
    steps(6);
    chk("cap_beats", 32'(nlog), 32'd4);
    steps(4);
    chk("cap_total", 32'(nlog), 32'd6);
    chk("cap_regrant", 32'(glog[1]), 32'd1);

    // full stall, then space opens
    do_reset();
    fcnt = DEPTH;
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b1);
    en[2] = 1'b1;
    steps(5);
    chk("full_nowr", 32'(nlog), 32'd0);
    fcnt = DEPTH - MB;
    steps(6);
    chk("full_nbeats", 32'(nlog), 32'd3);
    chk("full_d0", 32'(wlog[0]), 32'h20);
    chk("full_d2", 32'(wlog[2]), 32'h22);

    // abandon mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 8'(8'h40 + k), 1'b0);
    en[0] = 1'b1;
    steps(3);
    en[0] = 1'b0;
    steps(1);
    en[0] = 1'b1;
    en[1] = 1'b1;
    push(1, 8'h51, 1'b1);
    steps(4);
    chk("ab_next", 32'(glog[1]), 32'd1);
    chk("ab_data", 32'(wlog[2]), 32'h51);

    // reset mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) push(3, 8'(8'h70 + k), 1'b0);
    en[3] = 1'b1;
    steps(2);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    do_reset();
    push(0, 8'h01, 1'b1);
    push(3, 8'h31, 1'b1);
    en[0] = 1'b1;
    en[3] = 1'b1;
    steps(3);
    chk("post_rst", 32'(glog[0]), 32'd0);

    // random traffic
    do_reset();
    drain_pct = 85;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) drain_pct = (drain_pct == 85) ? 15 : 85;
      for (int i = 0; i < N; i++) begin
        if (wr[i] == rd[i] && $urandom_range(7) == 0) begin
          int len;
          bit nolast;
          len    = int'($urandom_range(6, 1));
          nolast = ($urandom_range(3) == 0);
          for (int k = 0; k < len; k++) begin
            push(i, 8'((i << 6) | (seq[i] & 63)),
                 !nolast && (k == len - 1));
            seq[i]++;
          end
        end
        if (en[i] && $urandom_range(39) == 0) en[i] = 1'b0;
        else if (!en[i] && $urandom_range(2) == 0) en[i] = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfifo_wr_arb.md
Name: sfifo_wr_arb

Overview:
- Round-robin burst arbiter sharing the write port of one synchronous FIFO among N producers.
- Each producer streams beats with req/last; the arbiter grants one producer at a time.
- It muxes the granted producer's data onto the FIFO write port and ends each burst on last, on a beat cap, or on abandonment.
- Sits directly in front of the FIFO write side (w_en, data_in, full, count).

Parameters:
- N_REQ, 4, number of producers (2..16)
- DATA_WIDTH, 8, beat width; equals FIFO data width
- ADDR_WIDTH, 7, FIFO address width; depth = 2**ADDR_WIDTH, count is ADDR_WIDTH+1 bits
- MAX_BURST, 4, maximum beats per grant (1..2**ADDR_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  N_REQ  per-producer beat valid
- req_last  in  N_REQ  per-producer last beat of burst, qualified by req
- req_data  in  N_REQ*DATA_WIDTH  packed beats; producer i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- ack  out  N_REQ  beat accepted this cycle, one-hot or zero
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_count  in  ADDR_WIDTH+1  FIFO occupancy
- grant_id  out  clog2(N_REQ)  current owner; valid while busy
- busy  out  1  a burst is granted

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, busy=0.
  - ack=0 and fifo_w_en=0 immediately, because both decode from state.
  - fifo_data_in=0, since the mux output is forced to 0 when not busy.
- States: IDLE and BURST.
- IDLE:
  - If any req bit is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Register grant_id, clear beat_cnt, go to BURST. No beat is accepted in IDLE.
  - Arbitration latency is 1 cycle from req to the first possible ack.
- BURST, with g=grant_id and accept = req[g] & ~fifo_full:
  - ack[g]=accept; fifo_w_en=accept; fifo_data_in=req_data[g]. All combinational, same cycle.
  - On accept, beat_cnt increments.
  - Burst ends (next state IDLE, rr_ptr=(g+1) mod N_REQ) when any of:
    - (a) accept & req_last[g];
    - (b) accept & beat_cnt==MAX_BURST-1;
    - (c) ~req[g] (abandon; no beat is written that cycle).
  - fifo_full with req[g]=1: stall. Hold the grant, no ack, no timeout.
- Handover: one idle bubble cycle between consecutive bursts. Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness: a producer requesting continuously is granted within N_REQ-1 other bursts.
- Requests from non-granted producers are ignored and never acked. Producers must hold req_data stable until ack.
- beat_cnt width: clog2(MAX_BURST+1). rr_ptr increment wraps modulo N_REQ, including non-power-of-2 N_REQ.
- Simultaneous last and cap on the same beat: single end of burst, same result.
- fifo_count is used only by the optional feature.

Optional Feature:
- Macro: SFIFO_WR_ARB_SPACE_CHECK_EN.
- Defined:
  - IDLE grants only when (2**ADDR_WIDTH - fifo_count) >= MAX_BURST, computed at ADDR_WIDTH+1 bits.
  - Otherwise it stays in IDLE with rr_ptr unchanged.
  - A granted burst therefore never sees fifo_full.
- Undefined: grant regardless of space; stall on fifo_full as described.

Decomposition:
- Package sfifo_wr_arb_pkg holds:
  - arb_state_t enum (IDLE, BURST);
  - a constant function for clog2;
  - the default MAX_BURST constant.
- Sub-module rr_pick (combinational):
  - inputs: req vector and rr_ptr;
  - outputs: found flag and index;
  - behaviour: rotate the request vector, priority-encode, un-rotate.

Test Plan:
- Single burst: N_REQ=4, req[2] held for 3 beats 0xA0,0xA1,0xA2 with last on 0xA2 -> grant_id=2 one cycle after req; FIFO receives exactly A0,A1,A2 on consecutive cycles; back to IDLE; rr_ptr=3.
- Round robin: all four req held, bursts of 2 with last -> grant order 0,1,2,3,0; one bubble cycle between bursts; 8 beats in 12 cycles.
- Cap: req[1] held with last never set, MAX_BURST=4 -> exactly 4 acks; re-arbitration then grants producer 1 again only if no other producer is requesting.
- Full stall: fifo_count=128 with full=1 during a burst -> ack=0 and fifo_w_en=0 while full; on full deassert, resumes with the same beat and no loss or duplication.
- Abandon and reset: producer 0 drops req mid-burst -> IDLE next cycle with rr_ptr=1. Assert rst mid-burst -> ack, fifo_w_en and busy go 0 in the same cycle; after release, grant starts from producer 0.
- With SFIFO_WR_ARB_SPACE_CHECK_EN: fifo_count=125, MAX_BURST=4 -> no grant; count drops to 124 -> grant next cycle.
